// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction fetch responder.
package fetch_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        VALID = 2'b11
    } ifr_state_t;

    // Word handed to the fetch stage when no real instruction is available (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Instruction-memory read port: req/gnt address phase plus rvalid data phase.
interface imem_fetch_responder_if #(
    parameter int size = 32
);
    logic              mem_req_o;
    logic [size-1:0]   mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [size-1:0]   mem_rdata_i;

    // Responder side drives the request, memory side answers
    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/imem_fetch_responder_watchdog.sv
// Watchdog for a hung memory: counts cycles while enabled and pulses
// o_expire on the cycle the count reaches TIMEOUT-1.
module fetch_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    // Cycle counter: cleared whenever the responder is not waiting on data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    assign o_expire = i_enable & (r_count == LAST_COUNT);

endmodule

// File: rtl/imem_fetch_responder.sv
// Memory-side partner of the fetch stage. Issues one outstanding read at a
// time, returns the word with a valid flag held under bubble, drops stale
// data after a redirect and substitutes a faulting NOP on timeout.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to fault misaligned PCs
// without touching memory.
module imem_fetch_responder #(
    parameter int size    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [size-1:0]                pc_i,
    input  logic                           buble_i,
    input  logic                           flush_i,
    output logic [size-1:0]                instruction_o,
    output logic                           instruction_valid_o,
    output logic                           fetch_fault_o,
    imem_fetch_responder_if.master         mem
);
    import fetch_pkg::*;

    ifr_state_t      r_state;
    ifr_state_t      w_nextState;
    logic            r_firstReq;
    logic            r_discard;
    logic [size-1:0] r_addr;
    logic [size-1:0] r_instr;
    logic            r_valid;
    logic            r_fault;

    logic            w_gnt;
    logic            w_expire;
    logic            w_misalign;
    logic            w_dropResp;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (r_state != WAIT),
        .i_enable (r_state == WAIT),
        .o_expire (w_expire)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    assign w_misalign = (r_state == REQ) & r_firstReq & ~flush_i & (|pc_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // A flush on the first REQ cycle withholds the request so the new target
    // can be sampled next cycle without ever changing a live address.
    assign mem.mem_req_o  = (r_state == REQ) & ~(r_firstReq & flush_i) & ~w_misalign;
    assign mem.mem_addr_o = ((r_state == REQ) && r_firstReq) ? pc_i : r_addr;

    assign w_gnt      = mem.mem_req_o & mem.mem_gnt_i;
    assign w_dropResp = r_discard | flush_i;

    // Next-state selection; flush always beats bubble and a redirected or
    // abandoned transaction always goes back to REQ to fetch the new target
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  w_nextState = REQ;
            REQ: begin
                if (w_misalign) begin
                    w_nextState = VALID;
                end else if (w_gnt) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid_i || w_expire) begin
                    w_nextState = w_dropResp ? REQ : VALID;
                end
            end
            VALID: begin
                if (flush_i || !buble_i) begin
                    w_nextState = REQ;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State, latched address, discard flag and registered fetch-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_firstReq <= 1'b0;
            r_discard  <= 1'b0;
            r_addr     <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_firstReq <= (w_nextState == REQ) &&
                          ((r_state != REQ) || (r_firstReq && flush_i));
            if ((r_state == REQ) && r_firstReq) begin
                r_addr <= pc_i;
            end
            case (r_state)
                REQ: begin
                    if (w_misalign) begin
                        r_instr <= size'(NOP_INSTR);
                        r_fault <= 1'b1;
                        r_valid <= 1'b1;
                    end else if (!r_firstReq && flush_i) begin
                        r_discard <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid_i) begin
                        r_discard <= 1'b0;
                        if (!w_dropResp) begin
                            r_instr <= mem.mem_rdata_i;
                            r_fault <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end else if (w_expire) begin
                        r_discard <= 1'b1;
                        if (!w_dropResp) begin
                            r_instr <= size'(NOP_INSTR);
                            r_fault <= 1'b1;
                            r_valid <= 1'b1;
                        end
                    end else if (flush_i) begin
                        r_discard <= 1'b1;
                    end
                end
                VALID: begin
                    if (flush_i || !buble_i) begin
                        r_valid <= 1'b0;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign instruction_o       = r_instr;
    assign instruction_valid_o = r_valid;
    assign fetch_fault_o       = r_fault;

`ifndef SYNTHESIS
    // Memory must only return data while a read is outstanding
    a_rvalidOnlyInWait: assert property (
        @(posedge clk) disable iff (!reset) mem.mem_rvalid_i |-> (r_state == WAIT)
    ) else $error("mem_rvalid_i asserted outside WAIT");
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed testbench for imem_fetch_responder (TIMEOUT=8). Inputs are driven
// just after the falling edge and outputs checked 1 time unit later.
module tb_imem_fetch_responder;

    logic        clk;
    logic        reset;
    logic [31:0] pcI;
    logic        bubleI;
    logic        flushI;
    logic [31:0] instrO;
    logic        validO;
    logic        faultO;

    int testsRun;
    int testsFailed;

    imem_fetch_responder_if #(.size(32)) memBus ();

    imem_fetch_responder #(
        .size    (32),
        .TIMEOUT (8)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .pc_i                (pcI),
        .buble_i             (bubleI),
        .flush_i             (flushI),
        .instruction_o       (instrO),
        .instruction_valid_o (validO),
        .fetch_fault_o       (faultO),
        .mem                 (memBus.master)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset assertion and checks of every output while reset is low, then release
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", validO); end
        testsRun++; if (instrO !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_instr: got %h expected 00000000", instrO); end
        testsRun++; if (faultO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fault: got %b expected 0", faultO); end
        testsRun++; if (memBus.mem_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req: got %b expected 0", memBus.mem_req_o); end
        testsRun++; if (memBus.mem_addr_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h expected 00000000", memBus.mem_addr_o); end
        @(negedge clk);
        reset = 1'b1;
        pcI   = 32'h100;
        #1;
        testsRun++; if (memBus.mem_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_req: got %b expected 0", memBus.mem_req_o); end
        @(negedge clk);
    endtask

    // Plain fetch: gnt in first REQ cycle, rvalid two cycles later, consumed at once
    task automatic test_basic();
        pcI = 32'h100;
        memBus.mem_gnt_i = 1'b1;
        #1;
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_req: got %b expected 1", memBus.mem_req_o); end
        testsRun++; if (memBus.mem_addr_o !== 32'h100) begin testsFailed++; $display("[TB] FAIL basic_addr: got %h expected 00000100", memBus.mem_addr_o); end
        @(negedge clk);
        memBus.mem_gnt_i = 1'b0;
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_wait_valid: got %b expected 0", validO); end
        testsRun++; if (memBus.mem_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_wait_req: got %b expected 0", memBus.mem_req_o); end
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'h0050_0093;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (validO !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_valid: got %b expected 1", validO); end
        testsRun++; if (instrO !== 32'h0050_0093) begin testsFailed++; $display("[TB] FAIL basic_instr: got %h expected 00500093", instrO); end
        testsRun++; if (faultO !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_fault: got %b expected 0", faultO); end
        @(negedge clk);
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_consumed: got %b expected 0", validO); end
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_rereq: got %b expected 1", memBus.mem_req_o); end
    endtask

    // Bubble held for 5 VALID cycles keeps the word stable, release consumes it
    task automatic test_bubble();
        pcI = 32'h104;
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'h00A0_0113;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        bubleI = 1'b1;
        #1;
        testsRun++; if (validO !== 1'b1) begin testsFailed++; $display("[TB] FAIL bubble_valid: got %b expected 1", validO); end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            #1;
            testsRun++; if (validO !== 1'b1) begin testsFailed++; $display("[TB] FAIL bubble_hold_valid[%0d]: got %b expected 1", i, validO); end
            testsRun++; if (instrO !== 32'h00A0_0113) begin testsFailed++; $display("[TB] FAIL bubble_hold_instr[%0d]: got %h expected 00a00113", i, instrO); end
        end
        @(negedge clk);
        bubleI = 1'b0;
        #1;
        testsRun++; if (validO !== 1'b1) begin testsFailed++; $display("[TB] FAIL bubble_release_valid: got %b expected 1", validO); end
        @(negedge clk);
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL bubble_consumed: got %b expected 0", validO); end
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL bubble_rereq: got %b expected 1", memBus.mem_req_o); end
    endtask

    // Flush on first WAIT cycle; the following rvalid is dropped and the new PC fetched
    task automatic test_flush_wait();
        pcI = 32'h108;
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i = 1'b0;
        flushI = 1'b1;
        @(negedge clk);
        flushI = 1'b0;
        pcI    = 32'h200;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL flushwait_dropped: got %b expected 0", validO); end
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL flushwait_req: got %b expected 1", memBus.mem_req_o); end
        testsRun++; if (memBus.mem_addr_o !== 32'h200) begin testsFailed++; $display("[TB] FAIL flushwait_addr: got %h expected 00000200", memBus.mem_addr_o); end
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'h0000_0013;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (validO !== 1'b1) begin testsFailed++; $display("[TB] FAIL flushwait_valid: got %b expected 1", validO); end
        testsRun++; if (instrO !== 32'h0000_0013) begin testsFailed++; $display("[TB] FAIL flushwait_instr: got %h expected 00000013", instrO); end
        testsRun++; if (faultO !== 1'b0) begin testsFailed++; $display("[TB] FAIL flushwait_fault: got %b expected 0", faultO); end
        @(negedge clk);
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL flushwait_consumed: got %b expected 0", validO); end
    endtask

    // Flush and rvalid together: data dropped, next request served normally
    task automatic test_flush_rvalid_same();
        pcI = 32'h10C;
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'h0000_0BAD;
        flushI = 1'b1;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        flushI = 1'b0;
        pcI    = 32'h300;
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL flushsame_valid: got %b expected 0", validO); end
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL flushsame_req: got %b expected 1", memBus.mem_req_o); end
        testsRun++; if (memBus.mem_addr_o !== 32'h300) begin testsFailed++; $display("[TB] FAIL flushsame_addr: got %h expected 00000300", memBus.mem_addr_o); end
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'h0010_0073;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (validO !== 1'b1) begin testsFailed++; $display("[TB] FAIL flushsame_next_valid: got %b expected 1", validO); end
        testsRun++; if (instrO !== 32'h0010_0073) begin testsFailed++; $display("[TB] FAIL flushsame_next_instr: got %h expected 00100073", instrO); end
        @(negedge clk);
        #1;
    endtask

    // Hung memory: after 8 WAIT cycles a faulting NOP appears; the late response is dropped
    task automatic test_timeout();
        pcI = 32'h110;
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i = 1'b0;
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_wait0: got %b expected 0", validO); end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            #1;
            testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_wait%0d: got %b expected 0", i, validO); end
        end
        @(negedge clk);
        #1;
        testsRun++; if (validO !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_valid: got %b expected 1", validO); end
        testsRun++; if (instrO !== 32'h0000_0013) begin testsFailed++; $display("[TB] FAIL timeout_instr: got %h expected 00000013", instrO); end
        testsRun++; if (faultO !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_fault: got %b expected 1", faultO); end
        @(negedge clk);
        #1;
        testsRun++; if (faultO !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_fault_clear: got %b expected 0", faultO); end
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_rereq: got %b expected 1", memBus.mem_req_o); end
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'hFEED_FACE;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_late_dropped: got %b expected 0", validO); end
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_late_rereq: got %b expected 1", memBus.mem_req_o); end
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'h0020_0093;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (instrO !== 32'h0020_0093) begin testsFailed++; $display("[TB] FAIL timeout_recover_instr: got %h expected 00200093", instrO); end
        testsRun++; if (faultO !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_recover_fault: got %b expected 0", faultO); end
        @(negedge clk);
        #1;
    endtask

    // Reset pulse while waiting: outputs clear, IDLE then REQ, stale data not taken
    task automatic test_reset_mid_wait();
        pcI = 32'h114;
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'hDEAD_0000;
        #1;
        testsRun++; if (instrO !== 32'h0) begin testsFailed++; $display("[TB] FAIL rstwait_instr: got %h expected 00000000", instrO); end
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstwait_valid: got %b expected 0", validO); end
        testsRun++; if (memBus.mem_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstwait_req: got %b expected 0", memBus.mem_req_o); end
        testsRun++; if (memBus.mem_addr_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL rstwait_addr: got %h expected 00000000", memBus.mem_addr_o); end
        @(negedge clk);
        reset = 1'b1;
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (memBus.mem_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstwait_idle_req: got %b expected 0", memBus.mem_req_o); end
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstwait_idle_valid: got %b expected 0", validO); end
        @(negedge clk);
        #1;
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstwait_req_again: got %b expected 1", memBus.mem_req_o); end
        testsRun++; if (memBus.mem_addr_o !== 32'h114) begin testsFailed++; $display("[TB] FAIL rstwait_addr_again: got %h expected 00000114", memBus.mem_addr_o); end
        memBus.mem_gnt_i = 1'b1;
        @(negedge clk);
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'h0030_0093;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (instrO !== 32'h0030_0093) begin testsFailed++; $display("[TB] FAIL rstwait_fresh_instr: got %h expected 00300093", instrO); end
        @(negedge clk);
        #1;
    endtask

    // Misaligned PC: faulted locally with the check enabled, passed through otherwise
    task automatic test_align();
        pcI = 32'h102;
`ifdef IFETCH_ALIGN_CHECK_EN
        #1;
        testsRun++; if (memBus.mem_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL align_noreq: got %b expected 0", memBus.mem_req_o); end
        @(negedge clk);
        #1;
        testsRun++; if (validO !== 1'b1) begin testsFailed++; $display("[TB] FAIL align_valid: got %b expected 1", validO); end
        testsRun++; if (instrO !== 32'h0000_0013) begin testsFailed++; $display("[TB] FAIL align_instr: got %h expected 00000013", instrO); end
        testsRun++; if (faultO !== 1'b1) begin testsFailed++; $display("[TB] FAIL align_fault: got %b expected 1", faultO); end
`else
        memBus.mem_gnt_i = 1'b1;
        #1;
        testsRun++; if (memBus.mem_req_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL align_req: got %b expected 1", memBus.mem_req_o); end
        testsRun++; if (memBus.mem_addr_o !== 32'h102) begin testsFailed++; $display("[TB] FAIL align_addr: got %h expected 00000102", memBus.mem_addr_o); end
        @(negedge clk);
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b1;
        memBus.mem_rdata_i  = 32'h0040_0093;
        @(negedge clk);
        memBus.mem_rvalid_i = 1'b0;
        #1;
        testsRun++; if (instrO !== 32'h0040_0093) begin testsFailed++; $display("[TB] FAIL align_instr: got %h expected 00400093", instrO); end
        testsRun++; if (faultO !== 1'b0) begin testsFailed++; $display("[TB] FAIL align_fault: got %b expected 0", faultO); end
`endif
        @(negedge clk);
        #1;
        testsRun++; if (validO !== 1'b0) begin testsFailed++; $display("[TB] FAIL align_consumed: got %b expected 0", validO); end
    endtask

    // Test sequence
    initial begin
        testsRun            = 0;
        testsFailed         = 0;
        reset               = 1'b0;
        pcI                 = 32'h0;
        bubleI              = 1'b0;
        flushI              = 1'b0;
        memBus.mem_gnt_i    = 1'b0;
        memBus.mem_rvalid_i = 1'b0;
        memBus.mem_rdata_i  = 32'h0;

        test_reset();
        test_basic();
        test_bubble();
        test_flush_wait();
        test_flush_rvalid_same();
        test_timeout();
        test_reset_mid_wait();
        test_align();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
